// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the shared data-memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    localparam int SC_SUCCESS = 0;
    localparam int SC_FAIL = 1;
    localparam int WORD_LSB = 2;
    localparam logic [2:0] func3_MEM_WA = 3'b011;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first requester after the last grant
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [$clog2(N)-1:0] ptr
);
    localparam int W = $clog2(N);
    // scan downwards so the requester closest after ptr is the last to overwrite
    always_comb begin
        grant = '0;
        grant_idx = ptr;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) grant_idx = W'((int'(ptr) + k) % N);
        end
        if (|req) grant[grant_idx] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= W'(N - 1);
        else if (enable && |req) ptr <= grant_idx;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one data-memory port among cores with round-robin grants
// and per-core LR/SC reservations for LWA/SWA.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CORES-1:0]          core_mem_read,
    input  logic [N_CORES-1:0]          core_mem_write,
    input  logic [N_CORES-1:0]          core_mem_atomic,
    input  logic [N_CORES*ADDR_W-1:0]   core_mem_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_mem_data_w,
    output logic [N_CORES*DATA_W-1:0]   core_mem_data_r,
    output logic [N_CORES-1:0]          core_mem_wait,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data_w,
    input  logic [DATA_W-1:0]           mem_data_r,
    input  logic                        mem_ready
);
    localparam int GW = $clog2(N_CORES);
    localparam int RW = ADDR_W - WORD_LSB;

    arb_state_t state, state_n;
    logic [N_CORES-1:0] req, grant_oh, done_oh, resv_valid;
    logic [GW-1:0] sel, grant;
    logic any_req, sel_write, sel_atomic, sel_swa, sc_ok, cur_write, cur_atomic;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [RW-1:0] resv_addr [N_CORES];

    assign req = core_mem_read | core_mem_write;
    assign any_req = |grant_oh;
    assign sel_write = core_mem_write[sel];
    assign sel_atomic = core_mem_atomic[sel];
    assign sel_swa = sel_write & sel_atomic;
    assign sel_addr = core_mem_addr[sel*ADDR_W +: ADDR_W];
    assign sel_data = core_mem_data_w[sel*DATA_W +: DATA_W];
    assign sc_ok = resv_valid[sel] && resv_addr[sel] == sel_addr[ADDR_W-1:WORD_LSB];
    assign done_oh = (state == DONE) ? N_CORES'(1) << grant : '0;
    assign core_mem_wait = req & ~done_oh;

    // the pointer always equals the core being served once it leaves IDLE
    rr_arbiter #(.N(N_CORES)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .enable    (state == IDLE),
        .grant     (grant_oh),
        .grant_idx (sel),
        .ptr       (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = (sel_swa && !sc_ok) ? DONE : ACCESS;
            ACCESS:  if (mem_ready) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_data_w <= '0;
            core_mem_data_r <= '0;
            cur_write <= 1'b0;
            cur_atomic <= 1'b0;
            resv_valid <= '0;
            for (int j = 0; j < N_CORES; j++) resv_addr[j] <= '0;
        end else if (state == IDLE && any_req) begin
            mem_addr <= sel_addr;
            mem_data_w <= sel_data;
            cur_write <= sel_write;
            cur_atomic <= sel_atomic;
            mem_read <= !sel_write;
            mem_write <= sel_write && (!sel_atomic || sc_ok);
            if (sel_swa) resv_valid[sel] <= 1'b0;
            if (sel_swa && !sc_ok) core_mem_data_r[sel*DATA_W +: DATA_W] <= DATA_W'(SC_FAIL);
        end else if (state == ACCESS && mem_ready) begin
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            // a plain store returns nothing; a dropped request discards its result
            if (req[grant] && !(cur_write && !cur_atomic))
                core_mem_data_r[grant*DATA_W +: DATA_W] <= cur_write ? DATA_W'(SC_SUCCESS) : mem_data_r;
            if (cur_write) begin
                for (int j = 0; j < N_CORES; j++)
                    if (resv_addr[j] == mem_addr[ADDR_W-1:WORD_LSB]) resv_valid[j] <= 1'b0;
            end else if (cur_atomic) begin
                resv_valid[grant] <= 1'b1;
                resv_addr[grant] <= mem_addr[ADDR_W-1:WORD_LSB];
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: transaction-level model of the shared port, directed scenarios
// followed by random multi-core LW/SW/LWA/SWA traffic.
module tb_mem_bus_arbiter;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] c_rd = '0, c_wr = '0, c_at = '0;
    logic [N*AW-1:0] c_addr = '0;
    logic [N*DW-1:0] c_dw = '0;
    logic [N*DW-1:0] c_dr;
    logic [N-1:0] c_wait;
    logic mem_read, mem_write;
    logic mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_w, mem_data_r;
    logic [31:0] mem_img [8];
    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // model: one transaction in flight, its owner, and what each core last received
    bit m_busy, m_strobe, m_done, m_wr, m_at, ok;
    int m_own, m_last, w;
    logic [31:0] m_addr, m_data;
    logic [31:0] m_res [N];
    bit m_rv [N];
    logic [29:0] m_ra [N];
    logic [31:0] exp_mem [8];

    mem_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_mem_read   (c_rd),
        .core_mem_write  (c_wr),
        .core_mem_atomic (c_at),
        .core_mem_addr   (c_addr),
        .core_mem_data_w (c_dw),
        .core_mem_data_r (c_dr),
        .core_mem_wait   (c_wait),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_data_w      (mem_data_w),
        .mem_data_r      (mem_data_r),
        .mem_ready       (mem_ready)
    );

    always #5 clk = ~clk;
    assign mem_data_r = mem_img[mem_addr[4:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_strobe = 0; m_done = 0; m_wr = 0; m_at = 0;
        m_own = 0; m_last = N - 1; m_addr = '0; m_data = '0;
        for (int i = 0; i < N; i++) begin
            m_res[i] = '0; m_rv[i] = 0; m_ra[i] = '0;
        end
    endfunction

    task automatic issue(input int i, input bit r, input bit wr, input bit a,
                         input logic [31:0] ad, input logic [31:0] d);
        c_rd[i] = r; c_wr[i] = wr; c_at[i] = a;
        c_addr[i*AW +: AW] = ad; c_dw[i*DW +: DW] = d;
    endtask

    task automatic drop(input int i);
        c_rd[i] = 0; c_wr[i] = 0; c_at[i] = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else if (!m_busy) begin
            if (|(c_rd | c_wr)) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && (c_rd[(m_last + k) % N] || c_wr[(m_last + k) % N])) w = (m_last + k) % N;
                m_last = w; m_own = w; m_busy = 1; m_strobe = 1;
                m_wr = c_wr[w]; m_at = c_at[w];
                m_addr = c_addr[w*AW +: AW]; m_data = c_dw[w*DW +: DW];
                if (m_wr && m_at) begin
                    ok = m_rv[w] && m_ra[w] == m_addr[31:2];
                    m_rv[w] = 0;
                    if (!ok) begin
                        m_strobe = 0; m_done = 1; m_res[w] = 32'd1;
                    end
                end
            end
        end else if (m_done) begin
            m_busy = 0; m_done = 0;
        end else if (mem_ready) begin
            m_strobe = 0; m_done = 1;
            if (m_wr) begin
                exp_mem[m_addr[4:2]] = m_data;
                for (int i = 0; i < N; i++) if (m_ra[i] == m_addr[31:2]) m_rv[i] = 0;
                if (m_at) m_res[m_own] = 32'd0;
            end else begin
                m_res[m_own] = exp_mem[m_addr[4:2]];
                if (m_at) begin
                    m_rv[m_own] = 1; m_ra[m_own] = m_addr[31:2];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_write && mem_ready && rst_n) mem_img[mem_addr[4:2]] = mem_data_w;
    end

    always @(negedge clk) if (chk_on) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wait[%0d]", i), c_wait[i], (c_rd[i] | c_wr[i]) && !(m_done && m_own == i));
            chk($sformatf("data_r[%0d]", i), c_dr[i*DW +: DW], m_res[i]);
        end
        chk("mem_read", mem_read, m_strobe && !m_wr);
        chk("mem_write", mem_write, m_strobe && m_wr);
        if (m_strobe) chk("mem_addr", mem_addr, m_addr);
        if (m_strobe && m_wr) chk("mem_data_w", mem_data_w, m_data);
    end

    task automatic run_one(input int i, output int nw, output int nr, output int nwr,
                           output logic [31:0] wd, output logic [31:0] dout);
        bit got = 0;
        nw = 0; nr = 0; nwr = 0; wd = '0; dout = '0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (mem_read) nr++;
            if (mem_write) begin
                nwr++; wd = mem_data_w;
            end
            if (c_wait[i]) nw++;
            else begin
                got = 1; dout = c_dr[i*DW +: DW];
            end
            @(posedge clk); #1;
        end
        chk($sformatf("completes_in_bound[%0d]", i), got, 1);
        drop(i);
    endtask

    initial begin
        logic [31:0] wd, dout;
        logic [1:0] op;
        logic [N-1:0] dn;
        int nw, nr, nwr, first;
        int order[$];
        for (int i = 0; i < 8; i++) mem_img[i] = $urandom;
        mem_img[0] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) exp_mem[i] = mem_img[i];
        model_reset();
        chk_on = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_data_r", |c_dr, 0);
        rst_n = 1;
        mem_ready = 1;

        for (int i = 0; i < N; i++) issue(i, 0, 1, 0, 32'h210 + 32'(4 * i), 32'(i + 1));
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (c_wr[i] && !c_wait[i]) order.push_back(i);
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) drop(i);
        chk("rr_grants", order.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_order[%0d]", k), k < order.size() ? order[k] : -1, k % N);

        issue(0, 1, 0, 0, 32'h100, 0);
        run_one(0, nw, nr, nwr, wd, dout);
        chk("lw_wait_cycles", nw, 2);
        chk("lw_read_cycles", nr, 1);
        chk("lw_data", dout, 32'hDEADBEEF);

        issue(1, 1, 0, 1, 32'h200, 0);
        run_one(1, nw, nr, nwr, wd, dout);
        issue(1, 0, 1, 1, 32'h200, 32'h55);
        run_one(1, nw, nr, nwr, wd, dout);
        chk("sc_ok_writes", nwr, 1);
        chk("sc_ok_wdata", wd, 32'h55);
        chk("sc_ok_result", dout, 0);
        issue(1, 0, 1, 1, 32'h200, 32'h66);
        run_one(1, nw, nr, nwr, wd, dout);
        chk("sc_again_writes", nwr, 0);
        chk("sc_again_result", dout, 1);
        chk("sc_again_wait_cycles", nw, 1);

        issue(1, 1, 0, 1, 32'h200, 0);
        run_one(1, nw, nr, nwr, wd, dout);
        issue(2, 0, 1, 0, 32'h202, 32'h77);
        run_one(2, nw, nr, nwr, wd, dout);
        issue(1, 0, 1, 1, 32'h200, 32'h99);
        run_one(1, nw, nr, nwr, wd, dout);
        chk("sc_broken_writes", nwr, 0);
        chk("sc_broken_result", dout, 1);

        mem_ready = 0;
        issue(0, 1, 0, 0, 32'h204, 0);
        @(posedge clk); #1;
        issue(3, 0, 1, 0, 32'h20C, 32'hABCD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_mem_read", mem_read, 1);
            chk("stall_mem_addr", mem_addr, 32'h204);
            chk("stall_wait0", c_wait[0], 1);
            chk("stall_wait3", c_wait[3], 1);
            @(posedge clk); #1;
        end
        mem_ready = 1;
        run_one(0, nw, nr, nwr, wd, dout);
        run_one(3, nw, nr, nwr, wd, dout);

        issue(2, 1, 0, 1, 32'h208, 0);
        run_one(2, nw, nr, nwr, wd, dout);
        mem_ready = 0;
        issue(1, 1, 0, 0, 32'h214, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_mem_read", mem_read, 1);
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        #1;
        chk("reset_now_mem_read", mem_read, 0);
        chk("reset_now_mem_write", mem_write, 0);
        chk("reset_wait_follows_req", c_wait[1], 1);
        repeat (2) @(posedge clk);
        #1;
        drop(1);
        mem_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
        issue(3, 1, 0, 0, 32'h218, 0);
        issue(0, 1, 0, 0, 32'h21C, 0);
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if ((c_rd[i] || c_wr[i]) && !c_wait[i]) first = i;
            @(posedge clk); #1;
        end
        chk("first_grant_after_reset", first, 0);
        drop(0);
        run_one(3, nw, nr, nwr, wd, dout);
        issue(2, 0, 1, 1, 32'h208, 32'h1234);
        run_one(2, nw, nr, nwr, wd, dout);
        chk("sc_after_reset_result", dout, 1);
        chk("sc_after_reset_writes", nwr, 0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dn = (c_rd | c_wr) & ~c_wait;
            @(posedge clk); #1;
            mem_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++) begin
                if (dn[i]) drop(i);
                if (!(c_rd[i] || c_wr[i]) && $urandom_range(0, 2) == 0) begin
                    op = 2'($urandom_range(0, 3));
                    issue(i, !op[0], op[0], op[1],
                          32'h200 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)), $urandom);
                end
            end
        end
        for (int i = 0; i < N; i++) drop(i);
        mem_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
